taillight_sequencer: RTL and testbench



---
 rtl/taillight_pkg.sv | 59 +++++
 rtl/taillight_sequencer_tick_gen.sv | 28 ++
 rtl/taillight_sequencer.sv | 71 +++++++
 tb/tb_taillight_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/taillight_pkg.sv
// Shared state encoding, lamp patterns and decode helpers for the taillight sequencer.
package taillight_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    L1   = 4'd1,
    L2   = 4'd2,
    L3   = 4'd3,
    LOFF = 4'd4,
    R1   = 4'd5,
    R2   = 4'd6,
    R3   = 4'd7,
    ROFF = 4'd8,
    HON  = 4'd9,
    HOFF = 4'd10
  } state_t;

  // Patterns are ordered {C, B, A}; A is the innermost lamp on each side.
  localparam logic [2:0] PAT_OFF = 3'b000;
  localparam logic [2:0] PAT_1   = 3'b001;
  localparam logic [2:0] PAT_2   = 3'b011;
  localparam logic [2:0] PAT_3   = 3'b111;

  typedef struct packed {
    logic [2:0] left_pat;
    logic [2:0] right_pat;
    logic       busy;
  } lamp_t;

  function automatic lamp_t lamp_decode(input state_t s);
    lamp_t l;
    l.left_pat  = PAT_OFF;
    l.right_pat = PAT_OFF;
    l.busy      = (s != IDLE);
    case (s)
      L1:  l.left_pat  = PAT_1;
      L2:  l.left_pat  = PAT_2;
      L3:  l.left_pat  = PAT_3;
      R1:  l.right_pat = PAT_1;
      R2:  l.right_pat = PAT_2;
      R3:  l.right_pat = PAT_3;
      HON: begin
        l.left_pat  = PAT_3;
        l.right_pat = PAT_3;
      end
      default: ;
    endcase
    return l;
  endfunction

  // Hazard, or both sides at once, outranks a single side request.
  function automatic state_t req_decode(input logic l, input logic r, input logic h);
    if (h || (l && r)) return HON;
    else if (l)        return L1;
    else if (r)        return R1;
    else               return IDLE;
  endfunction

endpackage

// File: rtl/taillight_sequencer_tick_gen.sv
// Step prescaler: one tick every TICK_DIV cycles, held cleared while the sequencer idles.
module tick_gen #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_sys) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == CNT_LAST) && !clear;

endmodule

// File: rtl/taillight_sequencer.sv
// Turn-signal sequencer: arbitrates left/right/hazard requests and steps the lamp patterns.
module taillight_sequencer
  import taillight_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic left,
  input  logic right,
  input  logic hazard,
  output logic LA,
  output logic LB,
  output logic LC,
  output logic RA,
  output logic RB,
  output logic RC,
  output logic busy
);

  state_t state;
  state_t state_next;
  lamp_t  lamp_q;
  logic   tick;
  logic   idle_c;

  assign idle_c = (state == IDLE);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (idle_c),
    .tick    (tick)
  );

  // Lamps are registered from the next-state decode so they track the state register exactly.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state  <= IDLE;
      lamp_q <= '0;
    end else begin
      state  <= state_next;
      lamp_q <= lamp_decode(state_next);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = req_decode(left, right, hazard);
      L1:   if (tick) state_next = hazard ? HON : L2;
      L2:   if (tick) state_next = hazard ? HON : L3;
      L3:   if (tick) state_next = hazard ? HON : LOFF;
      R1:   if (tick) state_next = hazard ? HON : R2;
      R2:   if (tick) state_next = hazard ? HON : R3;
      R3:   if (tick) state_next = hazard ? HON : ROFF;
      HON:  if (tick) state_next = HOFF;
      LOFF, ROFF, HOFF: if (tick) state_next = req_decode(left, right, hazard);
      default: state_next = IDLE;
    endcase
  end

  assign LA   = lamp_q.left_pat[0];
  assign LB   = lamp_q.left_pat[1];
  assign LC   = lamp_q.left_pat[2];
  assign RA   = lamp_q.right_pat[0];
  assign RB   = lamp_q.right_pat[1];
  assign RC   = lamp_q.right_pat[2];
  assign busy = lamp_q.busy;

endmodule

// File: tb/tb_taillight_sequencer.sv
// Directed scenarios for taillight_sequencer at TICK_DIV=4 with a per-cycle expectation queue.
module tb_taillight_sequencer;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic left    = 1'b0;
  logic right   = 1'b0;
  logic hazard  = 1'b0;
  logic LA, LB, LC, RA, RB, RC, busy;

  int errors = 0;
  int checks = 0;
  string tag = "init";
  logic [6:0] exp_q[$];

  taillight_sequencer #(.TICK_DIV(4)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .left    (left),
    .right   (right),
    .hazard  (hazard),
    .LA      (LA),
    .LB      (LB),
    .LC      (LC),
    .RA      (RA),
    .RB      (RB),
    .RC      (RC),
    .busy    (busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Expected output after a clock edge: {LC,LB,LA, RC,RB,RA, busy}.
  task automatic push(input logic [2:0] lp, input logic [2:0] rp, input logic b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({lp, rp, b});
  endtask

  task automatic push_left_seq();
    push(3'b001, 3'b000, 1'b1, 4);
    push(3'b011, 3'b000, 1'b1, 4);
    push(3'b111, 3'b000, 1'b1, 4);
    push(3'b000, 3'b000, 1'b1, 4);
  endtask

  task automatic push_right_seq();
    push(3'b000, 3'b001, 1'b1, 4);
    push(3'b000, 3'b011, 1'b1, 4);
    push(3'b000, 3'b111, 1'b1, 4);
    push(3'b000, 3'b000, 1'b1, 4);
  endtask

  task automatic push_idle(input int n);
    push(3'b000, 3'b000, 1'b0, n);
  endtask

  task automatic check_cycle();
    logic [6:0] obs;
    logic [6:0] exp;
    @(posedge clk_sys);
    #1;
    obs = {LC, LB, LA, RC, RB, RA, busy};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%b but no expectation queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
    end
  endtask

  task automatic drive(input logic rst, input logic l, input logic r, input logic h, input int n);
    reset  = rst;
    left   = l;
    right  = r;
    hazard = h;
    for (int i = 0; i < n; i++) check_cycle();
  endtask

  initial begin
    tag = "reset";
    push_idle(2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2);
    push_idle(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1);

    tag = "left_pulse";
    push_left_seq();
    push_idle(3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 18);

    tag = "left_held";
    push_left_seq();
    push_left_seq();
    push_left_seq();
    push_idle(2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 40);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 10);

    tag = "left_right_same";
    push(3'b111, 3'b111, 1'b1, 4);
    push(3'b000, 3'b000, 1'b1, 4);
    push_idle(2);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 9);

    tag = "hazard_preempt";
    push(3'b001, 3'b000, 1'b1, 4);
    push(3'b011, 3'b000, 1'b1, 4);
    push(3'b111, 3'b111, 1'b1, 4);
    push(3'b000, 3'b000, 1'b1, 4);
    push_idle(2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 9);

    tag = "right_during_left";
    push_left_seq();
    push_right_seq();
    push_idle(2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 17);

    tag = "reset_mid_l3";
    push(3'b001, 3'b000, 1'b1, 4);
    push(3'b011, 3'b000, 1'b1, 4);
    push(3'b111, 3'b000, 1'b1, 2);
    push_idle(1);
    push_left_seq();
    push_idle(2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 10);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 17);

    tag = "queue_drained";
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s: observed=%0d leftover expected=0", tag, exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
